pll_ce_gen: RTL and testbench

PLL_CE_GEN -- requirements
Module: pll_ce_gen

---
 rtl/pll_ce_pkg.sv | 31 +++
 rtl/bit_sync.sv | 25 ++
 rtl/pll_ce_gen.sv | 113 +++++++++++
 tb/tb_pll_ce_gen.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pll_ce_pkg.sv
// Shared types and constants for the PLL clock-enable generator.
// Holds the FSM state encoding, dot_sel encodings, divisors and the dot_sel decode.
package pll_ce_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam logic [1:0] DOT_SEL_16 = 2'b00;
  localparam logic [1:0] DOT_SEL_12 = 2'b01;
  localparam logic [1:0] DOT_SEL_8  = 2'b10;

  localparam logic [4:0] DIV_16 = 5'd16;
  localparam logic [4:0] DIV_12 = 5'd12;
  localparam logic [4:0] DIV_8  = 5'd8;

  localparam logic [1:0] MASTER_TERM = 2'd3;
  localparam logic [3:0] CPU_TERM    = 4'd11;

  // Both 10 and 11 select the fastest dot clock.
  function automatic logic [4:0] dot_div(input logic [1:0] sel);
    case (sel)
      DOT_SEL_16: return DIV_16;
      DOT_SEL_12: return DIV_12;
      default:    return DIV_8;
    endcase
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Flops clear to 0 on reset so the output reads "not asserted" until proven otherwise.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync[0] <= d;
      for (int i = 1; i < STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/pll_ce_gen.sv
// Core reset sequencer and phase-aligned clock-enable generator behind the system PLL.
// Holds the core in reset until lock has been stable long enough, then divides clk_sys.
module pll_ce_gen
  import pll_ce_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic [1:0] dot_sel,
  input  logic       lost_clr,
  output logic       sys_reset,
  output logic       ce_master,
  output logic       ce_cpu,
  output logic       ce_dot,
  output logic       lock_lost
);

  localparam int SCW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SCW-1:0] STABLE_LAST = SCW'(STABLE_CYCLES - 1);

  logic           lock_s;
  state_t         state, state_nxt;
  logic [SCW-1:0] stable_cnt;
  logic [1:0]     master_cnt;
  logic [3:0]     cpu_cnt;
  logic [3:0]     dot_cnt;
  logic [4:0]     dot_div_q;
  logic           run_nxt, run_entry;
  logic           master_wrap, cpu_wrap, dot_wrap;

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk_sys),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= WAIT_LOCK;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOCK: if (lock_s) state_nxt = STABLE;
      STABLE: begin
        if (!lock_s)                       state_nxt = WAIT_LOCK;
        else if (stable_cnt == STABLE_LAST) state_nxt = RUN;
      end
      RUN:       if (!lock_s) state_nxt = WAIT_LOCK;
      default:   state_nxt = WAIT_LOCK;
    endcase
  end

  // Any lock drop sends the count back to zero, so re-lock always waits the full window.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                       stable_cnt <= '0;
    else if (state == STABLE && lock_s) stable_cnt <= stable_cnt + 1'b1;
    else                              stable_cnt <= '0;
  end

  assign run_nxt     = (state_nxt == RUN);
  assign run_entry   = run_nxt && (state != RUN);
  assign master_wrap = (master_cnt == MASTER_TERM);
  assign cpu_wrap    = (cpu_cnt == CPU_TERM);
  assign dot_wrap    = ({1'b0, dot_cnt} == (dot_div_q - 5'd1));

  // Counters step on the edge entering RUN, so the registered enables land on
  // RUN cycles 4k / 12k / dot_div*k and all coincide every 48 cycles.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      master_cnt <= '0;
      cpu_cnt    <= '0;
      dot_cnt    <= '0;
      dot_div_q  <= DIV_16;
      ce_master  <= 1'b0;
      ce_cpu     <= 1'b0;
      ce_dot     <= 1'b0;
    end else if (!run_nxt) begin
      master_cnt <= '0;
      cpu_cnt    <= '0;
      dot_cnt    <= '0;
      ce_master  <= 1'b0;
      ce_cpu     <= 1'b0;
      ce_dot     <= 1'b0;
    end else begin
      master_cnt <= master_wrap ? 2'd0 : master_cnt + 2'd1;
      cpu_cnt    <= cpu_wrap    ? 4'd0 : cpu_cnt + 4'd1;
      dot_cnt    <= dot_wrap    ? 4'd0 : dot_cnt + 4'd1;
      ce_master  <= master_wrap;
      ce_cpu     <= cpu_wrap;
      ce_dot     <= dot_wrap;
      if (run_entry || dot_wrap) dot_div_q <= dot_div(dot_sel);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) sys_reset <= 1'b1;
    else        sys_reset <= !run_nxt;
  end

  // Set takes priority over clear so a drop coinciding with lost_clr is never lost.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                     lock_lost <= 1'b0;
    else if (state == RUN && !lock_s) lock_lost <= 1'b1;
    else if (lost_clr)              lock_lost <= 1'b0;
  end

endmodule

// File: tb/tb_pll_ce_gen.sv
// Directed bench for pll_ce_gen with STABLE_CYCLES = 16 and SYNC_STAGES = 2.
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
module tb_pll_ce_gen;

  localparam int SC       = 16;
  localparam int SS       = 2;
  localparam int LOCK_LAT = SS + SC + 1;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic [1:0] dot_sel;
  logic       lost_clr;
  logic       sys_reset, ce_master, ce_cpu, ce_dot, lock_lost;

  int n_vec = 0;
  int n_bad = 0;
  int cm, cc, cd;

  always #5 clk_sys = ~clk_sys;

  pll_ce_gen #(.STABLE_CYCLES(SC), .SYNC_STAGES(SS)) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .dot_sel    (dot_sel),
    .lost_clr   (lost_clr),
    .sys_reset  (sys_reset),
    .ce_master  (ce_master),
    .ce_cpu     (ce_cpu),
    .ce_dot     (ce_dot),
    .lock_lost  (lock_lost)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    dot_sel    = 2'b01;
    lost_clr   = 1'b0;
    repeat (3) tick();
    chk("rst_sys_reset", 32'(sys_reset), 1);
    chk("rst_ce", 32'({ce_master, ce_cpu, ce_dot}), 0);
    chk("rst_lock_lost", 32'(lock_lost), 0);

    // Test 1: lock from reset, release after SS+SC+1 edges
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    for (int t = 1; t < LOCK_LAT; t++) begin
      tick();
      chk("t1_hold_reset", 32'(sys_reset), 1);
      chk("t1_no_ce", 32'({ce_master, ce_cpu, ce_dot}), 0);
    end
    tick();
    chk("t1_release", 32'(sys_reset), 0);

    // Test 2: /12 dot clock, 96 RUN cycles starting at cycle 1
    cm = 0; cc = 0; cd = 0;
    for (int n = 1; n <= 96; n++) begin
      chk("t2_ce", 32'({ce_master, ce_cpu, ce_dot}),
          32'({n % 4 == 0, n % 12 == 0, n % 12 == 0}));
      if (n == 48 || n == 96) chk("t2_align", 32'({ce_master, ce_cpu, ce_dot}), 32'b111);
      cm += int'(ce_master);
      cc += int'(ce_cpu);
      cd += int'(ce_dot);
      tick();
    end
    chk("t2_master_count", 32'(cm), 24);
    chk("t2_cpu_count", 32'(cc), 8);
    chk("t2_dot_count", 32'(cd), 8);

    // Test 3: /12 -> /16 at next wrap (cycle 108), then 00 -> 10 at dot count 5
    dot_sel = 2'b00;
    for (int rc = 97; rc <= 141; rc++) begin
      chk("t3_dot", 32'(ce_dot), 32'(rc == 108 || rc == 124 || rc == 132 || rc == 140));
      chk("t3_master", 32'(ce_master), 32'(rc % 4 == 0));
      if (rc == 113) dot_sel = 2'b10;
      tick();
    end

    // Test 4: lock dropped for 4 cycles in RUN
    pll_locked = 1'b0;
    tick();
    chk("t4_drop1", 32'(sys_reset), 0);
    tick();
    chk("t4_drop2", 32'(sys_reset), 0);
    tick();
    chk("t4_reset", 32'(sys_reset), 1);
    chk("t4_ce_off", 32'({ce_master, ce_cpu, ce_dot}), 0);
    chk("t4_lock_lost", 32'(lock_lost), 1);
    tick();
    chk("t4_still_reset", 32'(sys_reset), 1);
    pll_locked = 1'b1;
    for (int t = 1; t < LOCK_LAT; t++) begin
      tick();
      chk("t4_relock_wait", 32'(sys_reset), 1);
      chk("t4_relock_no_ce", 32'({ce_master, ce_cpu, ce_dot}), 0);
      chk("t4_sticky", 32'(lock_lost), 1);
    end
    tick();
    chk("t4_relock_run", 32'(sys_reset), 0);

    // Test 6a: clear, then clear colliding with a set
    lost_clr = 1'b1;
    tick();
    chk("t6_clr", 32'(lock_lost), 0);
    lost_clr = 1'b0;
    tick();
    chk("t6_clr_hold", 32'(lock_lost), 0);
    lost_clr   = 1'b1;
    pll_locked = 1'b0;
    tick();
    chk("t6_pre_set1", 32'(lock_lost), 0);
    tick();
    chk("t6_pre_set2", 32'(lock_lost), 0);
    tick();
    chk("t6_set_wins", 32'(lock_lost), 1);
    chk("t6_set_reset", 32'(sys_reset), 1);
    lost_clr = 1'b0;
    tick();
    chk("t6_set_sticky", 32'(lock_lost), 1);
    lost_clr = 1'b1;
    tick();
    chk("t6_clr_again", 32'(lock_lost), 0);
    lost_clr = 1'b0;

    // Test 5: lock lost for 2 cycles during STABLE restarts the count
    pll_locked = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk("t5_stable", 32'(sys_reset), 1);
    end
    pll_locked = 1'b0;
    tick();
    chk("t5_glitch1_lost", 32'(lock_lost), 0);
    tick();
    chk("t5_glitch2_lost", 32'(lock_lost), 0);
    pll_locked = 1'b1;
    for (int t = 1; t < LOCK_LAT; t++) begin
      tick();
      chk("t5_restart_wait", 32'(sys_reset), 1);
      chk("t5_lost_clear", 32'(lock_lost), 0);
    end
    tick();
    chk("t5_run", 32'(sys_reset), 0);

    // Test 6b: asynchronous reset mid-RUN while ce_master is high
    repeat (3) tick();
    chk("t6_pre_master", 32'(ce_master), 1);
    #1 rst_n = 1'b0;
    #2;
    chk("t6_async_sys_reset", 32'(sys_reset), 1);
    chk("t6_async_ce", 32'({ce_master, ce_cpu, ce_dot}), 0);
    chk("t6_async_lost", 32'(lock_lost), 0);
    repeat (2) tick();
    chk("t6_held_reset", 32'(sys_reset), 1);
    rst_n = 1'b1;
    for (int t = 1; t < LOCK_LAT; t++) begin
      tick();
      chk("t6_rerun_wait", 32'(sys_reset), 1);
    end
    tick();
    chk("t6_rerun", 32'(sys_reset), 0);
    chk("t6_rerun_lost", 32'(lock_lost), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
